// File: rtl/retire_trace_serializer.sv
// Buffers 92-bit retire snapshots in a FIFO, tags each with a sequence number and
// streams it as a byte frame (SYNC, seq, P0..P11); define TRACE_CRC_EN to append CRC-8.
module retire_trace_serializer #(
    parameter int         DEPTH     = 8,
    parameter int         LVL_W     = $clog2(DEPTH) + 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trace_en,
    input  logic             retire_valid,
    input  logic [91:0]      retire_data,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic [15:0]      drop_count,
    input  logic             clear_status
);

    localparam int PTR_W = $clog2(DEPTH);

`ifdef TRACE_CRC_EN
    typedef enum logic [2:0] {IDLE, SYNC, SEQ, PAY, CRC} state_t;
`else
    typedef enum logic [1:0] {IDLE, SYNC, SEQ, PAY} state_t;
`endif

    logic [99:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       seq_cnt;

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [3:0]  idx_next;
    logic [99:0] frame;
    logic [99:0] frame_next;
    logic        out_valid_next;
    logic [7:0]  out_data_next;
`ifdef TRACE_CRC_EN
    logic [7:0]  crc;
    logic [7:0]  crc_next;
`endif

    logic capture;
    logic fifo_full;
    logic fifo_empty;
    logic accept;
    logic frame_slot_free;
    logic pop;
    logic push;
    logic drop;

    // Payload is {4'b0, snapshot}, byte k counted from the most significant end.
    function automatic logic [7:0] payload_byte(input logic [91:0] snap, input logic [3:0] k);
        logic [95:0] p;
        p = {4'b0000, snap};
        return p[8 * (11 - int'(k)) +: 8];
    endfunction

`ifdef TRACE_CRC_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic [7:0] data_in);
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`endif

    assign capture    = trace_en & retire_valid;
    assign fifo_full  = (fifo_level == LVL_W'(DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign accept     = out_valid & out_ready;
    assign push       = capture & (~fifo_full | pop);
    assign drop       = capture & ~push;

    always_comb begin
        state_next      = state;
        idx_next        = idx;
        frame_next      = frame;
        out_valid_next  = out_valid;
        out_data_next   = out_data;
        frame_slot_free = 1'b0;
        pop             = 1'b0;
`ifdef TRACE_CRC_EN
        crc_next        = crc;
`endif
        case (state)
            IDLE: frame_slot_free = 1'b1;
            SYNC: begin
                if (accept) begin
                    state_next    = SEQ;
                    out_data_next = frame[99:92];
                end
            end
            SEQ: begin
                if (accept) begin
                    state_next    = PAY;
                    idx_next      = 4'd0;
                    out_data_next = payload_byte(frame[91:0], 4'd0);
`ifdef TRACE_CRC_EN
                    crc_next      = crc8_step(crc, out_data);
`endif
                end
            end
            PAY: begin
                if (accept) begin
`ifdef TRACE_CRC_EN
                    crc_next = crc8_step(crc, out_data);
`endif
                    if (idx == 4'd11) begin
`ifdef TRACE_CRC_EN
                        state_next    = CRC;
                        out_data_next = crc8_step(crc, out_data);
`else
                        frame_slot_free = 1'b1;
`endif
                    end else begin
                        idx_next      = idx + 4'd1;
                        out_data_next = payload_byte(frame[91:0], idx + 4'd1);
                    end
                end
            end
`ifdef TRACE_CRC_EN
            CRC: begin
                if (accept) frame_slot_free = 1'b1;
            end
`endif
            default: state_next = IDLE;
        endcase

        // Starting the next frame on the same edge keeps back-to-back frames gapless.
        if (frame_slot_free) begin
            if (!fifo_empty) begin
                pop            = 1'b1;
                frame_next     = fifo_mem[rd_ptr];
                state_next     = SYNC;
                out_valid_next = 1'b1;
                out_data_next  = SYNC_BYTE;
`ifdef TRACE_CRC_EN
                crc_next       = 8'h00;
`endif
            end else begin
                state_next     = IDLE;
                out_valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            frame     <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
`ifdef TRACE_CRC_EN
            crc       <= 8'h00;
`endif
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            frame     <= frame_next;
            out_valid <= out_valid_next;
            out_data  <= out_data_next;
`ifdef TRACE_CRC_EN
            crc       <= crc_next;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= {seq_cnt, retire_data};
    end

    // The sequence counter advances on every capture, stored or dropped, so gaps are visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            seq_cnt    <= 8'd0;
        end else begin
            if (capture) seq_cnt <= seq_cnt + 8'd1;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (clear_status) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_retire_trace_serializer.sv
// Directed self-checking bench for retire_trace_serializer; honours TRACE_CRC_EN
// (15-byte frames with a CRC-8 checked against a bit-serial model).
module tb_retire_trace_serializer;

`ifdef TRACE_CRC_EN
    localparam int FL = 15;
`else
    localparam int FL = 14;
`endif

    logic        clock;
    logic        reset;
    logic        trace_en;
    logic        retire_valid;
    logic [91:0] retire_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;
    logic        clear_status;

    int checks;
    int errors;

    logic [7:0] exp_frame [0:14];
    logic [7:0] golden [0:14];

    // pc=0150 sp=FFFE b=00 c=13 d=00 e=D8 h=01 l=4D a=01 flags=B
    localparam logic [91:0] DEMO = 92'h0150FFFE001300D8014D01B;

    retire_trace_serializer dut (
        .clock        (clock),
        .reset        (reset),
        .trace_en     (trace_en),
        .retire_valid (retire_valid),
        .retire_data  (retire_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .clear_status (clear_status)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] crc_bitwise(input logic [7:0] crc_in, input logic [7:0] b);
        logic [7:0] c;
        logic fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
        return c;
    endfunction

    function automatic logic [91:0] pattern_data(input int i);
        return {8'(i), 84'h0123456789ABCDEF01234};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        retire_valid = 1'b0;
        clear_status = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic issue_retire(input logic [91:0] d);
        retire_valid = 1'b1;
        retire_data  = d;
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic build_expected(input logic [7:0] s, input logic [91:0] d);
        logic [95:0] p;
        logic [7:0]  c;
        p = {4'h0, d};
        exp_frame[0] = 8'hA5;
        exp_frame[1] = s;
        for (int k = 0; k < 12; k++) exp_frame[2 + k] = p[95 - 8 * k -: 8];
        c = 8'h00;
        for (int k = 1; k < 14; k++) c = crc_bitwise(c, exp_frame[k]);
        exp_frame[14] = c;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_level !== 4'd0 ||
            overflow !== 1'b0 || drop_count !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b d=%h lvl=%0d ovf=%b drops=%0d expected 0,00,0,0,0",
                     out_valid, out_data, fifo_level, overflow, drop_count);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] c;
        golden = '{8'hA5, 8'h00, 8'h00, 8'h15, 8'h0F, 8'hFF, 8'hE0, 8'h01,
                   8'h30, 8'h0D, 8'h80, 8'h14, 8'hD0, 8'h1B, 8'h00};
        c = 8'h00;
        for (int k = 1; k < 14; k++) c = crc_bitwise(c, golden[k]);
        golden[14] = c;
        out_ready = 1'b1;
        issue_retire(DEMO);
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd1) begin
            errors++;
            $display("[TB] FAIL single_latency: got v=%b lvl=%0d expected v=0 lvl=1", out_valid, fifo_level);
        end
        tick();
        for (int i = 0; i < FL; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== golden[i]) begin
                errors++;
                $display("[TB] FAIL single_byte%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, golden[i]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("[TB] FAIL single_end: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, fifo_level);
        end
    endtask

    task automatic test_backpressure();
        int         n;
        logic       stalled;
        logic [7:0] held;
        build_expected(8'd1, DEMO);
        out_ready = 1'b0;
        issue_retire(DEMO);
        n = 0;
        for (int cyc = 0; cyc < 400 && n < FL; cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_frame[n]) begin
                    errors++;
                    $display("[TB] FAIL bp_byte%0d: got %h expected %h", n, out_data, exp_frame[n]);
                end
                n++;
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
            tick();
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("[TB] FAIL bp_stall_hold: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, held);
                end
            end
        end
        checks++;
        if (n != FL) begin
            errors++;
            $display("[TB] FAIL bp_timeout: got %0d bytes expected %0d", n, FL);
        end
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            retire_valid = 1'b1;
            retire_data  = pattern_data(i);
            tick();
        end
        retire_valid = 1'b0;
        // seq 0 already sits in the frame register, seq 1..8 fill the FIFO, seq 9 is lost
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL overflow_status: got lvl=%0d ovf=%b drops=%0d expected 8,1,1",
                     fifo_level, overflow, drop_count);
        end
        out_ready = 1'b1;
        for (int f = 0; f < 9; f++) begin
            build_expected(8'(f), pattern_data(f));
            for (int n = 0; n < FL; n++) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_frame[n]) begin
                    errors++;
                    $display("[TB] FAIL drain_f%0d_b%0d: got v=%b d=%h expected v=1 d=%h",
                             f, n, out_valid, out_data, exp_frame[n]);
                end
                tick();
            end
        end
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            errors++;
            $display("[TB] FAIL drain_end: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, fifo_level);
        end
        issue_retire(pattern_data(10));
        tick();
        tick();
        checks++;
        if (out_data !== 8'd10) begin
            errors++;
            $display("[TB] FAIL seq_after_gap: got %h expected 0a", out_data);
        end
        repeat (FL + 2) tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        int         n;
        logic       started;
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            build_expected(8'(f), pattern_data(20 + f));
            for (int k = 0; k < FL; k++) q.push_back(exp_frame[k]);
        end
        n = 0;
        started = 1'b0;
        for (int cyc = 0; cyc < 100 && n < 3 * FL; cyc++) begin
            retire_valid = (cyc < 3);
            retire_data  = pattern_data(20 + cyc);
            tick();
            if (out_valid) started = 1'b1;
            if (started) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== q[n]) begin
                    errors++;
                    $display("[TB] FAIL b2b_byte%0d: got v=%b d=%h expected v=1 d=%h", n, out_valid, out_data, q[n]);
                end
                n++;
            end
        end
        retire_valid = 1'b0;
        checks++;
        if (n != 3 * FL) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: got %0d bytes expected %0d", n, 3 * FL);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_end: got v=%b expected v=0", out_valid);
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue_retire(pattern_data(i));
            repeat (15) tick();
        end
        issue_retire(pattern_data(256));
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL wrap_sync: got v=%b d=%h expected v=1 d=a5", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_data !== 8'h00 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap_seq: got seq=%h drops=%0d ovf=%b expected 00,0,0", out_data, drop_count, overflow);
        end
        repeat (FL + 2) tick();
    endtask

    task automatic test_reset_midframe();
        do_reset();
        out_ready = 1'b1;
        build_expected(8'd0, pattern_data(30));
        for (int i = 0; i < 3; i++) begin
            retire_valid = 1'b1;
            retire_data  = pattern_data(30 + i);
            tick();
        end
        retire_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_data !== exp_frame[5] || fifo_level !== 4'd2) begin
            errors++;
            $display("[TB] FAIL midframe_pos: got d=%h lvl=%0d expected d=%h lvl=2", out_data, fifo_level, exp_frame[5]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || fifo_level !== 4'd0 ||
            overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%b d=%h lvl=%0d ovf=%b drops=%0d expected 0,00,0,0,0",
                     out_valid, out_data, fifo_level, overflow, drop_count);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_discard: got v=%b expected v=0", out_valid);
        end
        issue_retire(pattern_data(40));
        tick();
        tick();
        checks++;
        if (out_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_seq: got %h expected 00", out_data);
        end
        repeat (FL + 2) tick();
    endtask

    task automatic test_clear_status();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            retire_valid = 1'b1;
            retire_data  = pattern_data(50 + i);
            tick();
        end
        checks++;
        if (fifo_level !== 4'd8 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_fill: got lvl=%0d ovf=%b expected 8,0", fifo_level, overflow);
        end
        tick();
        checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_first_drop: got ovf=%b drops=%0d expected 1,1", overflow, drop_count);
        end
        clear_status = 1'b1;
        tick();
        clear_status = 1'b0;
        checks++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clr_priority: got ovf=%b drops=%0d expected 0,0", overflow, drop_count);
        end
        tick();
        retire_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_resume: got ovf=%b drops=%0d expected 1,1", overflow, drop_count);
        end
        do_reset();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        trace_en     = 1'b1;
        retire_valid = 1'b0;
        retire_data  = '0;
        out_ready    = 1'b0;
        clear_status = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_seq_wrap();
        test_reset_midframe();
        test_clear_status();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
